// File: rtl/pc_ctrl_pkg.sv
// Shared constants for the PC sequencer: state encodings, widths, default step,
// and the target-alignment helper.
package pc_ctrl_pkg;

    localparam int PC_W        = 32;
    localparam int CNT_W       = 16;
    localparam int PC_STEP_DEF = 4;

    // Encodings are visible on the STATE port, so they are fixed values.
    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_FETCH  = 2'b01;
    localparam logic [1:0] ST_HALTED = 2'b10;

    // Redirect targets are word aligned: the low two bits are dropped.
    function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] a);
        return {a[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/pc_seq_ctrl_pc_reg.sv
// Program counter storage: synchronous active-high reset to RESET_PC and a
// load enable, so the PC only moves on an accepted fetch.
module pc_reg
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [PC_W-1:0] d,
    output logic [PC_W-1:0] q
);

    // Reset wins over load; otherwise hold unless loaded.
    always_ff @(posedge clk) begin
        if (rst)
            q <= RESET_PC;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pc_seq_ctrl.sv
// Fetch sequencer: small IDLE/FETCH/HALTED FSM, next-PC selection and a
// saturating count of accepted fetches. PC itself lives in pc_reg.
module pc_seq_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int              PC_STEP  = PC_STEP_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             STALL,
    input  logic             JMP,
    input  logic [PC_W-1:0]  JMP_TARGET,
    input  logic             BR_TAKEN,
    input  logic [PC_W-1:0]  BR_TARGET,
    input  logic             HALT_REQ,
    input  logic             IMEM_READY,
    output logic             IMEM_REQ,
    output logic [PC_W-1:0]  PC,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] INSTR_CNT
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             accept;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] cnt;

    // Request is purely a function of state and stall; redirects never
    // latch, they only matter on the cycle the memory takes the request.
    assign IMEM_REQ  = (state == ST_FETCH) && !STALL;
    assign accept    = IMEM_REQ && IMEM_READY;
    assign STATE     = state;
    assign INSTR_CNT = cnt;

    // Next PC: jump beats branch beats sequential step (wraps at 2^32).
    always_comb begin
        pc_nxt = PC + PC_W'(PC_STEP);
        if (JMP)
            pc_nxt = align_word(JMP_TARGET);
        else if (BR_TAKEN)
            pc_nxt = align_word(BR_TARGET);
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk  (CLK),
        .rst  (RST),
        .load (accept),
        .d    (pc_nxt),
        .q    (PC)
    );

    // Next state: halt beats EN=0; an accept in the leaving cycle still
    // updates PC/count because those depend only on accept.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE: begin
                if (HALT_REQ)
                    state_nxt = ST_HALTED;
                else if (EN)
                    state_nxt = ST_FETCH;
                else
                    state_nxt = ST_IDLE;
            end
            ST_FETCH: begin
                if (HALT_REQ)
                    state_nxt = ST_HALTED;
                else if (!EN)
                    state_nxt = ST_IDLE;
                else
                    state_nxt = ST_FETCH;
            end
            ST_HALTED: state_nxt = ST_HALTED;
            default:   state_nxt = ST_IDLE;   // stray 2'b11 recovers
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Accepted-fetch counter, sticks at all-ones.
    always_ff @(posedge CLK) begin
        if (RST)
            cnt <= '0;
        else if (accept && (cnt != {CNT_W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule
